// File: rtl/char_sched_pkg.sv
// Shared types and constants for the keyboard-to-display/sound character scheduler.
package char_sched_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam logic [CHAR_W-1:0] NULL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    PLAY,
    GAP
  } state_e;

endpackage

// File: rtl/char_fifo.sv
// Character FIFO with extra-MSB pointers; head is the entry at the read pointer
// (read-first), and a push into a full FIFO is accepted when a pop happens the same cycle.
module char_fifo
  import char_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [CHAR_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [CHAR_W-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_push_en;
  logic              w_pop_en;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_en  = i_pop && !o_empty;
  assign w_push_en = i_push && (!o_full || w_pop_en);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_en) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_en)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge i_clk) begin
    if (w_push_en) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/char_event_scheduler.sv
// Queues key characters, commits each to the display on a frame boundary, then sounds it
// for a fixed note time followed by a silent gap.
module char_event_scheduler
  import char_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [CHAR_W-1:0] kbd_char,
  input  logic              kbd_valid,
  input  logic              frame_start,
  output logic [CHAR_W-1:0] vga_char,
  output logic              vga_update,
  output logic [CHAR_W-1:0] snd_char,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e            r_state,      w_state_d;
  logic [CNT_W-1:0]  r_cnt,        w_cnt_d;
  logic [CHAR_W-1:0] r_cur,        w_cur_d;
  logic [CHAR_W-1:0] r_vga_char,   w_vga_char_d;
  logic [CHAR_W-1:0] r_snd_char,   w_snd_char_d;
  logic              r_vga_update, w_vga_update_d;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CHAR_W-1:0] w_head;

  // The null code means "no key" and is never queued.
  assign w_push = kbd_valid && (kbd_char != NULL_CHAR);

  char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_100MHz),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (kbd_char),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_cur_d        = r_cur;
    w_vga_char_d   = r_vga_char;
    w_vga_update_d = 1'b0;
    w_snd_char_d   = r_snd_char;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_cur_d   = w_head;
          w_state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          w_vga_char_d   = r_cur;
          w_vga_update_d = 1'b1;
          w_snd_char_d   = r_cur;
          w_cnt_d        = NOTE_LOAD;
          w_state_d      = PLAY;
        end
      end
      PLAY: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_ONE;
        end else begin
          w_snd_char_d = NULL_CHAR;
          w_cnt_d      = GAP_LOAD;
          w_state_d    = GAP;
        end
      end
      GAP: begin
        if (r_cnt != '0) w_cnt_d = r_cnt - CNT_ONE;
        else             w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cur        <= NULL_CHAR;
      r_vga_char   <= NULL_CHAR;
      r_vga_update <= 1'b0;
      r_snd_char   <= NULL_CHAR;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_cur        <= w_cur_d;
      r_vga_char   <= w_vga_char_d;
      r_vga_update <= w_vga_update_d;
      r_snd_char   <= w_snd_char_d;
      // A same-cycle pop frees the slot, so only an unpaired push into a full FIFO drops.
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign vga_char   = r_vga_char;
  assign vga_update = r_vga_update;
  assign snd_char   = r_snd_char;
  assign busy       = (r_state != IDLE);
  assign fifo_full  = w_full;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_char_event_scheduler.sv
// Self-checking bench: scenario tasks plus randomized traffic against a timestamp-based model.
module tb_char_event_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NOTE  = 10;
  localparam int unsigned GAP   = 4;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b1;
  logic [7:0] kbd_char    = 8'h00;
  logic       kbd_valid   = 1'b0;
  logic       frame_start = 1'b0;
  wire  [7:0] vga_char;
  wire  [7:0] snd_char;
  wire        vga_update;
  wire        busy;
  wire        fifo_full;
  wire        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  char_event_scheduler #(
    .DEPTH       (DEPTH),
    .NOTE_CYCLES (NOTE),
    .GAP_CYCLES  (GAP),
    .CNT_W       (25)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (rst_n),
    .kbd_char    (kbd_char),
    .kbd_valid   (kbd_valid),
    .frame_start (frame_start),
    .vga_char    (vga_char),
    .vga_update  (vga_update),
    .snd_char    (snd_char),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  wire [19:0] dut_vec = {vga_char, vga_update, snd_char, busy, fifo_full, overflow};

  // Reference model: a queue plus absolute edge timestamps for note end and return to idle.
  logic [7:0] m_q[$];
  logic [7:0] m_cur, m_vga_char, m_snd;
  bit         m_upd, m_busy, m_wait, m_ovf;
  longint     n_edge = 0;
  longint     t_note_end = 0;
  longint     t_idle = 0;

  function automatic logic [19:0] exp_vec();
    exp_vec = {m_vga_char, m_upd, m_snd, m_busy, (m_q.size() == DEPTH), m_ovf};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur = 8'h00; m_vga_char = 8'h00; m_snd = 8'h00;
    m_upd = 0; m_busy = 0; m_wait = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] c, input logic f);
    n_edge++;
    m_upd = 0;
    if (!m_busy && m_q.size() != 0) begin
      m_cur  = m_q.pop_front();
      m_busy = 1;
      m_wait = 1;
    end else if (m_busy && m_wait) begin
      if (f) begin
        m_vga_char = m_cur;
        m_upd      = 1;
        m_snd      = m_cur;
        m_wait     = 0;
        t_note_end = n_edge + NOTE;
        t_idle     = n_edge + NOTE + GAP;
      end
    end else if (m_busy) begin
      if (n_edge == t_note_end) m_snd = 8'h00;
      if (n_edge == t_idle) m_busy = 0;
    end
    if (v && c != 8'h00) begin
      if (m_q.size() < DEPTH) m_q.push_back(c);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic f);
    kbd_valid = v; kbd_char = c; frame_start = f;
    @(posedge clk);
    model_edge(v, c, f);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    kbd_valid = 0; kbd_char = 8'h00; frame_start = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    model_reset();
    #2;
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++; $display("FAIL reset_async: got %h want 00000", dut_vec);
    end
    @(negedge clk);
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++; $display("FAIL reset_hold: got %h want 00000", dut_vec);
    end
    @(negedge clk);
    rst_n = 1;
    step(0, 8'h00, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_char();
    int snd_hi = 0;
    int upd_cnt = 0;
    apply_reset();
    step(1, 8'h1C, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00, (i == 19));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL single_wait cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (vga_update) upd_cnt++;
      if (snd_char == 8'h1C) snd_hi++;
    end
    for (int i = 0; i < 24; i++) begin
      step(0, 8'h00, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL single_play cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (vga_update) upd_cnt++;
      if (snd_char == 8'h1C) snd_hi++;
    end
    checks++;
    if (snd_hi != NOTE) begin
      errors++; $display("FAIL single_note_len: got %0d want %0d", snd_hi, NOTE);
    end
    checks++;
    if (upd_cnt != 1) begin
      errors++; $display("FAIL single_update_cnt: got %0d want 1", upd_cnt);
    end
    checks++;
    if (vga_char !== 8'h1C || busy !== 1'b0) begin
      errors++; $display("FAIL single_end: got char %h busy %b want 1c 0", vga_char, busy);
    end
  endtask

  task automatic test_null_char();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h00, (i == 2));
      checks++;
      if (dut_vec !== exp_vec() || busy !== 1'b0 || fifo_full !== 1'b0) begin
        errors++; $display("FAIL null_push cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] chars [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B, 8'h34};
    logic [7:0] want  [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};
    logic [7:0] got[$];
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, chars[i], 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ovf_fill cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got ovf %b full %b want 1 1", overflow, fifo_full);
    end
    for (int i = 0; i < 150; i++) begin
      step(0, 8'h00, (i % 20 == 5));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ovf_drain cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (vga_update) got.push_back(vga_char);
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL ovf_count: got %0d want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    int guard = 0;
    apply_reset();
    step(1, 8'h11, 0);
    for (int i = 0; i < 4; i++) step(1, 8'h12 + 8'(i), 0);
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++; $display("FAIL fullpop_setup: got full %b want 1", fifo_full);
    end
    step(0, 8'h00, 1);
    while (m_busy && guard < 40) begin
      step(0, 8'h00, 0);
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++; $display("FAIL fullpop_timeout: got %0d cycles want <40", guard);
    end
    step(1, 8'h16, 0);
    checks++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL fullpop_accept: got %h want %h ovf 0", dut_vec, exp_vec());
    end
    for (int i = 0; i < 120; i++) begin
      step(0, 8'h00, (i % 20 == 3));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fullpop_drain cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (vga_char !== 8'h16) begin
      errors++; $display("FAIL fullpop_last: got %h want 16", vga_char);
    end
  endtask

  task automatic test_frame_ignored();
    int upd = 0;
    apply_reset();
    step(1, 8'h41, 0);
    step(1, 8'h42, 0);
    step(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00, (i < 15));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL frame_ign cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (vga_update) upd++;
    end
    checks++;
    if (upd != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL frame_ign_upd: got %0d busy %b want 0 1", upd, busy);
    end
    step(0, 8'h00, 1);
    checks++;
    if (vga_update !== 1'b1 || vga_char !== 8'h42 || snd_char !== 8'h42) begin
      errors++; $display("FAIL frame_next: got upd %b char %h want 1 42", vga_update, vga_char);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h51 + 8'(i), 0);
    step(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
    checks++;
    if (snd_char !== 8'h51 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got snd %h busy %b want 51 1", snd_char, busy);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++; $display("FAIL midrst_async: got %h want 00000", dut_vec);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, (i == 2));
      checks++;
      if (dut_vec !== exp_vec() || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_after cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic       v, f;
    logic [7:0] c;
    apply_reset();
    for (int i = 0; i < 900; i++) begin
      v = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      f = ($urandom_range(0, 12) == 0);
      step(v, c, f);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_char();
    test_null_char();
    test_overflow();
    test_full_pop();
    test_frame_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
